// File: rtl/psram_test_pkg.sv
// Shared encodings for the PSRAM self-test engine: FSM states, pattern modes and
// default LFSR constants.
package psram_test_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_REQ  = 4'd1,
    ST_WR_ACK  = 4'd2,
    ST_WR_NEXT = 4'd3,
    ST_RD_REQ  = 4'd4,
    ST_RD_ACK  = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_NADDR   = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/psram_pattern_gen.sv
// Test-pattern source shared by the write and check phases: mode mux over the
// current word address plus a Galois LFSR that the FSM reloads and steps per word.
module psram_pattern_gen
  import psram_test_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(DEF_LFSR_SEED)
) (
  input  logic              clk_100mhz,
  input  logic              rstn_i,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] addr,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_next;
  logic [DATA_W-1:0] alt;

  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) lfsr_next = lfsr_next ^ LFSR_TAPS;
  end

  // 0101... (5555 for 16 bits); its complement gives AAAA.
  always_comb begin
    alt = '0;
    for (int i = 0; i < int'(DATA_W); i++) alt[i] = (i % 2 == 0);
  end

  // NOTE: state registers use non-blocking assignments and are cleared by the
  // asynchronous reset; combinational logic above uses blocking with defaults first.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i)   lfsr <= LFSR_SEED;
    else if (load) lfsr <= LFSR_SEED;
    else if (step) lfsr <= lfsr_next;
  end

  always_comb begin
    pattern = addr;
    case (mode)
      MODE_ADDR:    pattern = addr;
      MODE_NADDR:   pattern = ~addr;
      MODE_LFSR:    pattern = lfsr;
      MODE_CHECKER: pattern = addr[0] ? alt : ~alt;
      default:      pattern = addr;
    endcase
  end

endmodule

// File: rtl/psram_bist.sv
// PSRAM built-in self-test: writes a pattern over [lo, hi] through the controller
// stb/busy handshake, reads it back, and reports error count and first failure.
module psram_bist
  import psram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ERR_W     = 16,
  parameter int unsigned       TIMEOUT_W = 12,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(DEF_LFSR_SEED)
) (
  input  logic              clk_100mhz,
  input  logic              rstn_i,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic              i_stop_on_err,
  input  logic [ADDR_W-1:0] i_addr_lo,
  input  logic [ADDR_W-1:0] i_addr_hi,
  output logic              o_mem_stb,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic              i_mem_busy,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [DATA_W-1:0] o_first_err_exp,
  output logic [DATA_W-1:0] o_first_err_got,
  output logic [3:0]        o_state
);

  state_t                state;
  mode_t                 mode;
  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W-1:0]     lo;
  logic [ADDR_W-1:0]     hi;
  logic [DATA_W-1:0]     rd_data;
  logic [DATA_W-1:0]     pattern;
  logic [TIMEOUT_W-1:0]  wd;
  logic                  wd_expired;
  logic                  at_hi;
  logic                  mismatch;
  logic                  pat_load;
  logic                  pat_step;

  assign at_hi      = (addr == hi);
  assign mismatch   = (rd_data != pattern);
  assign wd_expired = (wd == '1);

  assign o_mem_addr = addr;
  assign o_mem_din  = pattern;
  assign o_state    = state;

  // LFSR control mirrors the FSM word-advance decisions so both phases see one sequence.
  always_comb begin
    pat_load = 1'b0;
    pat_step = 1'b0;
    case (state)
      ST_IDLE:    pat_load = i_start;
      ST_WR_NEXT: begin
        if (!i_abort) begin
          if (at_hi) pat_load = 1'b1;
          else       pat_step = 1'b1;
        end
      end
      ST_CHECK:   pat_step = !(mismatch && i_stop_on_err) && !i_abort && !at_hi;
      default:    ;
    endcase
  end

  psram_pattern_gen #(
    .DATA_W    (DATA_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk_100mhz (clk_100mhz),
    .rstn_i     (rstn_i),
    .mode       (mode),
    .addr       (DATA_W'(addr)),
    .load       (pat_load),
    .step       (pat_step),
    .pattern    (pattern)
  );

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= ST_IDLE;
      mode             <= MODE_ADDR;
      addr             <= '0;
      lo               <= '0;
      hi               <= '0;
      rd_data          <= '0;
      wd               <= '0;
      o_mem_stb        <= 1'b0;
      o_mem_we         <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
      o_first_err_exp  <= '0;
      o_first_err_got  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          wd <= '0;
          if (i_start) begin
            mode             <= mode_t'(i_mode);
            lo               <= i_addr_lo;
            hi               <= i_addr_hi;
            addr             <= i_addr_lo;
            o_pass           <= 1'b0;
            o_timeout        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_got  <= '0;
            if (i_addr_hi < i_addr_lo) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= ST_WR_REQ;
              o_busy    <= 1'b1;
              o_mem_stb <= 1'b1;
              o_mem_we  <= 1'b1;
            end
          end
        end

        ST_WR_REQ, ST_RD_REQ: begin
          if (i_mem_busy) begin
            state     <= (state == ST_WR_REQ) ? ST_WR_ACK : ST_RD_ACK;
            o_mem_stb <= 1'b0;
            o_mem_we  <= 1'b0;
            wd        <= '0;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            o_mem_stb <= 1'b0;
            o_mem_we  <= 1'b0;
          end else begin
            wd <= wd + TIMEOUT_W'(1);
          end
        end

        ST_WR_ACK, ST_RD_ACK: begin
          if (!i_mem_busy) begin
            state <= (state == ST_WR_ACK) ? ST_WR_NEXT : ST_CHECK;
            wd    <= '0;
            if (state == ST_RD_ACK) rd_data <= i_mem_dout;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            wd <= wd + TIMEOUT_W'(1);
          end
        end

        ST_WR_NEXT: begin
          wd <= '0;
          if (i_abort) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (at_hi) begin
            addr      <= lo;
            state     <= ST_RD_REQ;
            o_mem_stb <= 1'b1;
            o_mem_we  <= 1'b0;
          end else begin
            addr      <= addr + ADDR_W'(1);
            state     <= ST_WR_REQ;
            o_mem_stb <= 1'b1;
            o_mem_we  <= 1'b1;
          end
        end

        ST_CHECK: begin
          wd <= '0;
          if (mismatch) begin
            if (o_err_count != '1) o_err_count <= o_err_count + ERR_W'(1);
            if (o_err_count == '0) begin
              o_first_err_addr <= addr;
              o_first_err_exp  <= pattern;
              o_first_err_got  <= rd_data;
            end
          end
          // End-of-range is tested before incrementing, so hi = all-ones never wraps.
          if ((mismatch && i_stop_on_err) || i_abort) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (at_hi) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_pass <= !mismatch && (o_err_count == '0);
          end else begin
            addr      <= addr + ADDR_W'(1);
            state     <= ST_RD_REQ;
            o_mem_stb <= 1'b1;
          end
        end

        ST_DONE: begin
          wd    <= '0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bist.sv
// Bench for psram_bist: a behavioural controller model scoreboards every request
// against expected operations queued by each scenario task.
module tb_psram_bist;
  import psram_test_pkg::*;

  logic        clk_100mhz = 1'b0;
  logic        rstn_i = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic        i_stop_on_err = 1'b0;
  logic [23:0] i_addr_lo = '0;
  logic [23:0] i_addr_hi = '0;
  logic        o_mem_stb, o_mem_we;
  logic [23:0] o_mem_addr;
  logic [15:0] o_mem_din;
  logic        i_mem_busy = 1'b0;
  logic [15:0] i_mem_dout = '0;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;
  logic [23:0] o_first_err_addr;
  logic [15:0] o_first_err_exp, o_first_err_got;
  logic [3:0]  o_state;

  always #5 clk_100mhz = ~clk_100mhz;

  psram_bist dut (
    .clk_100mhz       (clk_100mhz),
    .rstn_i           (rstn_i),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_mode           (i_mode),
    .i_stop_on_err    (i_stop_on_err),
    .i_addr_lo        (i_addr_lo),
    .i_addr_hi        (i_addr_hi),
    .o_mem_stb        (o_mem_stb),
    .o_mem_we         (o_mem_we),
    .o_mem_addr       (o_mem_addr),
    .o_mem_din        (o_mem_din),
    .i_mem_busy       (i_mem_busy),
    .i_mem_dout       (i_mem_dout),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_timeout        (o_timeout),
    .o_err_count      (o_err_count),
    .o_first_err_addr (o_first_err_addr),
    .o_first_err_exp  (o_first_err_exp),
    .o_first_err_got  (o_first_err_got),
    .o_state          (o_state)
  );

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } op_t;

  op_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          stb_cnt = 0;
  bit          never_busy = 1'b0;
  bit          fault_en = 1'b0;
  logic [15:0] mem [logic [23:0]];

  // Controller model: busy rises 3 cycles after a request is seen, lasts 8 cycles.
  int          phase = 0;
  int          cnt = 0;
  op_t         cur;
  op_t         exp_op;

  always @(negedge clk_100mhz) begin
    if (o_done === 1'b1) done_cnt++;
    if (o_mem_stb === 1'b1) stb_cnt++;
    if (!rstn_i) begin
      i_mem_busy = 1'b0;
      phase = 0;
      cnt = 0;
    end else begin
      case (phase)
        0: if (o_mem_stb === 1'b1 && !never_busy) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_op: got we=%0b addr=%h din=%h, want no request",
                     o_mem_we, o_mem_addr, o_mem_din);
          end else begin
            exp_op = sb.pop_front();
            if (o_mem_we !== exp_op.we || o_mem_addr !== exp_op.addr ||
                (exp_op.we && o_mem_din !== exp_op.data)) begin
              errors++;
              $display("FAIL op: got we=%0b addr=%h din=%h, want we=%0b addr=%h din=%h",
                       o_mem_we, o_mem_addr, o_mem_din, exp_op.we, exp_op.addr, exp_op.data);
            end
          end
          cur.we = o_mem_we;
          cur.addr = o_mem_addr;
          cur.data = o_mem_din;
          cnt = 0;
          phase = 1;
        end
        1: begin
          cnt++;
          if (cnt == 3) begin
            i_mem_busy = 1'b1;
            if (cur.we) mem[cur.addr] = cur.data;
            cnt = 0;
            phase = 2;
          end
        end
        default: begin
          cnt++;
          if (cnt == 8) begin
            if (!cur.we)
              i_mem_dout = (fault_en && cur.addr == 24'd2) ? (mem[cur.addr] ^ 16'h0001) : mem[cur.addr];
            i_mem_busy = 1'b0;
            phase = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [15:0] pat(input logic [1:0] m, input logic [23:0] a, input logic [15:0] l);
    case (m)
      2'd0:    return a[15:0];
      2'd1:    return ~a[15:0];
      2'd2:    return l;
      default: return a[0] ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  // Queue writes lo..hi then reads lo..last_rd with the bench's own pattern model.
  task automatic push_run(input logic [1:0] m, input logic [23:0] lo, input logic [23:0] hi,
                          input logic [23:0] last_rd);
    logic [15:0] l;
    op_t o;
    l = 16'hACE1;
    for (longint a = lo; a <= longint'(hi); a++) begin
      o.we = 1'b1; o.addr = 24'(a); o.data = pat(m, 24'(a), l);
      sb.push_back(o);
      l = lfsr_adv(l);
    end
    for (longint a = lo; a <= longint'(last_rd); a++) begin
      o.we = 1'b0; o.addr = 24'(a); o.data = '0;
      sb.push_back(o);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [23:0] lo, input logic [23:0] hi,
                           input logic stop);
    @(negedge clk_100mhz);
    i_mode = m; i_addr_lo = lo; i_addr_hi = hi; i_stop_on_err = stop;
    i_start = 1'b1;
    done_cnt = 0;
    stb_cnt = 0;
    @(negedge clk_100mhz);
    i_start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done_cnt == 0 && cycles < budget) begin
      @(negedge clk_100mhz);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (o_mem_stb !== 1'b0 || o_mem_we !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_pass !== 1'b0 || o_timeout !== 1'b0 || o_err_count !== 16'd0 ||
        o_first_err_addr !== 24'd0 || o_state !== 4'd0 || o_mem_din !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got stb=%0b busy=%0b pass=%0b err=%0d state=%0d, want all zero",
               o_mem_stb, o_busy, o_pass, o_err_count, o_state);
    end
  endtask

  task automatic test_basic;
    int cyc;
    push_run(2'd0, 24'd0, 24'd3, 24'd3);
    start_run(2'd0, 24'd0, 24'd3, 1'b0);
    wait_done(1000, cyc);
    repeat (5) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, want 1", done_cnt); end
    checks++;
    if (o_pass !== 1'b1 || o_err_count !== 16'd0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got pass=%0b err=%0d to=%0b, want 1 0 0", o_pass, o_err_count, o_timeout);
    end
    checks++;
    if (sb.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ops_left: got %0d pending busy=%0b, want 0 pending busy=0", sb.size(), o_busy);
    end
  endtask

  task automatic test_mismatch;
    int cyc;
    fault_en = 1'b1;
    push_run(2'd1, 24'd0, 24'd7, 24'd7);
    start_run(2'd1, 24'd0, 24'd7, 1'b0);
    wait_done(2000, cyc);
    checks++;
    if (o_err_count !== 16'd1 || o_pass !== 1'b0) begin
      errors++;
      $display("FAIL mm_count: got err=%0d pass=%0b, want 1 0", o_err_count, o_pass);
    end
    checks++;
    if (o_first_err_addr !== 24'd2 || o_first_err_exp !== 16'hFFFD || o_first_err_got !== 16'hFFFC) begin
      errors++;
      $display("FAIL mm_first: got addr=%h exp=%h got=%h, want 000002 FFFD FFFC",
               o_first_err_addr, o_first_err_exp, o_first_err_got);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL mm_ops_left: got %0d, want 0", sb.size()); end
    fault_en = 1'b0;
  endtask

  task automatic test_stop_on_err;
    int cyc;
    logic [15:0] l;
    fault_en = 1'b1;
    l = lfsr_adv(lfsr_adv(16'hACE1));
    push_run(2'd2, 24'd0, 24'd7, 24'd2);
    start_run(2'd2, 24'd0, 24'd7, 1'b1);
    wait_done(2000, cyc);
    repeat (30) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1 || o_err_count !== 16'd1 || o_pass !== 1'b0) begin
      errors++;
      $display("FAIL stop_status: got done=%0d err=%0d pass=%0b, want 1 1 0", done_cnt, o_err_count, o_pass);
    end
    checks++;
    if (o_first_err_addr !== 24'd2 || o_first_err_exp !== l || o_first_err_got !== (l ^ 16'h0001)) begin
      errors++;
      $display("FAIL stop_first: got addr=%h exp=%h got=%h, want 000002 %h %h",
               o_first_err_addr, o_first_err_exp, o_first_err_got, l, l ^ 16'h0001);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stop_ops_left: got %0d, want 0", sb.size()); end
    fault_en = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc;
    never_busy = 1'b1;
    start_run(2'd0, 24'd0, 24'd0, 1'b0);
    wait_done(5000, cyc);
    #1;
    checks++;
    if (done_cnt !== 1 || cyc < 4090 || cyc > 4105) begin
      errors++;
      $display("FAIL timeout_latency: got done=%0d after %0d cycles, want 1 after ~4096", done_cnt, cyc);
    end
    checks++;
    if (o_timeout !== 1'b1 || o_pass !== 1'b0 || o_mem_stb !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: got to=%0b pass=%0b stb=%0b busy=%0b, want 1 0 0 0",
               o_timeout, o_pass, o_mem_stb, o_busy);
    end
    never_busy = 1'b0;
  endtask

  task automatic test_bad_range;
    int cyc;
    start_run(2'd0, 24'd10, 24'd5, 1'b0);
    wait_done(2, cyc);
    repeat (10) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1 || o_pass !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL range_status: got done=%0d pass=%0b to=%0b, want 1 0 0", done_cnt, o_pass, o_timeout);
    end
    checks++;
    if (stb_cnt !== 0) begin errors++; $display("FAIL range_stb: got %0d stb cycles, want 0", stb_cnt); end
  endtask

  task automatic test_top_boundary;
    int cyc;
    push_run(2'd3, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    start_run(2'd3, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    wait_done(500, cyc);
    repeat (20) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1 || o_pass !== 1'b1 || o_err_count !== 16'd0) begin
      errors++;
      $display("FAIL top_status: got done=%0d pass=%0b err=%0d, want 1 1 0", done_cnt, o_pass, o_err_count);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL top_ops_left: got %0d, want 0", sb.size()); end
  endtask

  task automatic test_abort;
    int cyc;
    op_t o;
    o.we = 1'b1; o.addr = 24'd4; o.data = 16'h0004;
    sb.push_back(o);
    @(negedge clk_100mhz);
    i_abort = 1'b1;
    start_run(2'd0, 24'd4, 24'd9, 1'b0);
    wait_done(500, cyc);
    i_abort = 1'b0;
    repeat (10) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1 || o_pass !== 1'b0 || o_timeout !== 1'b0 || o_err_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_status: got done=%0d pass=%0b to=%0b err=%0d, want 1 0 0 0",
               done_cnt, o_pass, o_timeout, o_err_count);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL abort_ops_left: got %0d, want 0", sb.size()); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    fault_en = 1'b1;
    push_run(2'd0, 24'd0, 24'd3, 24'd3);
    start_run(2'd0, 24'd0, 24'd3, 1'b0);
    repeat (20) @(negedge clk_100mhz);
    i_mode = 2'd1; i_addr_lo = 24'd5; i_addr_hi = 24'd6;
    i_start = 1'b1;
    @(negedge clk_100mhz);
    i_start = 1'b0;
    wait_done(1000, cyc);
    repeat (10) @(negedge clk_100mhz);
    #1;
    checks++;
    if (done_cnt !== 1 || o_err_count !== 16'd1 || o_first_err_addr !== 24'd2 ||
        o_first_err_exp !== 16'h0002 || o_first_err_got !== 16'h0003) begin
      errors++;
      $display("FAIL busy_start: got done=%0d err=%0d addr=%h exp=%h got=%h, want 1 1 000002 0002 0003",
               done_cnt, o_err_count, o_first_err_addr, o_first_err_exp, o_first_err_got);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL busy_ops_left: got %0d, want 0", sb.size()); end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int n;
    push_run(2'd0, 24'd0, 24'd1, 24'd1);
    start_run(2'd0, 24'd0, 24'd1, 1'b0);
    n = 0;
    while (o_state !== ST_RD_ACK && n < 300) begin
      @(negedge clk_100mhz);
      #1;
      n++;
    end
    checks++;
    if (o_state !== ST_RD_ACK) begin
      errors++;
      $display("FAIL rst_reach_rd_ack: got state=%0d, want %0d", o_state, ST_RD_ACK);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if (o_mem_stb !== 1'b0 || o_busy !== 1'b0 || o_state !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_op: got stb=%0b busy=%0b state=%0d, want 0 0 0", o_mem_stb, o_busy, o_state);
    end
    repeat (3) @(negedge clk_100mhz);
    sb.delete();
    rstn_i = 1'b1;
    repeat (20) @(negedge clk_100mhz);
    #1;
    checks++;
    if (o_mem_stb !== 1'b0 || o_state !== 4'd0) begin
      errors++;
      $display("FAIL rst_quiet: got stb=%0b state=%0d, want 0 0", o_mem_stb, o_state);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_100mhz);
    #1;
    test_reset;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    test_basic;
    test_mismatch;
    test_stop_on_err;
    test_timeout;
    test_bad_range;
    test_top_boundary;
    test_abort;
    test_start_while_busy;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
